// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: CRC seed, FCS size, inserter FSM states and keep-mask helpers.
package eth_pkg;

  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
  localparam int          FCS_BYTES  = 4;
  localparam int          MAX_BYTES  = 8;

  typedef enum logic {PASS, EXTRA} fcs_state_t;

  function automatic logic [3:0] keep_to_count(input logic [MAX_BYTES-1:0] keep);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_BYTES; i++) cnt = cnt + {3'b000, keep[i]};
    return cnt;
  endfunction

  function automatic logic [MAX_BYTES-1:0] count_to_keep(input logic [3:0] cnt);
    logic [MAX_BYTES-1:0] keep;
    keep = '0;
    for (int i = 0; i < MAX_BYTES; i++) keep[i] = (4'(i) < cnt);
    return keep;
  endfunction

endpackage

// File: rtl/slicing_crc.sv
// Reflected CRC-32 (poly EDB88320) over up to SLICE_LENGTH contiguous bytes per clock.
// i_reset is synchronous; o_crc is combinational over the running value plus the current beat unless REGISTER_OUTPUT.
module slicing_crc #(
  parameter int          SLICE_LENGTH    = 8,
  parameter logic [31:0] INITIAL_CRC     = 32'hFFFFFFFF,
  parameter bit          INVERT_OUTPUT   = 1'b1,
  parameter bit          REGISTER_OUTPUT = 1'b0
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [8*SLICE_LENGTH-1:0] i_data,
  input  logic [SLICE_LENGTH-1:0]   i_valid,
  output logic [31:0]               o_crc
);

  localparam logic [31:0] POLY = 32'hEDB88320;

  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [31:0] crc_out;

  always_comb begin
    crc_d = crc_q;
    for (int i = 0; i < SLICE_LENGTH; i++) begin
      if (i_valid[i]) begin
        crc_d = crc_d ^ {24'h000000, i_data[8*i +: 8]};
        for (int b = 0; b < 8; b++) begin
          crc_d = crc_d[0] ? ((crc_d >> 1) ^ POLY) : (crc_d >> 1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) crc_q <= INITIAL_CRC;
    else         crc_q <= crc_d;
  end

  assign crc_out = INVERT_OUTPUT ? ~crc_d : crc_d;

  generate
    if (REGISTER_OUTPUT) begin : g_reg_out
      logic [31:0] crc_r;
      always_ff @(posedge i_clk) begin
        if (i_reset) crc_r <= INVERT_OUTPUT ? ~INITIAL_CRC : INITIAL_CRC;
        else         crc_r <= crc_out;
      end
      assign o_crc = crc_r;
    end else begin : g_comb_out
      assign o_crc = crc_out;
    end
  endgenerate

endmodule

// File: rtl/eth_fcs_inserter.sv
// Appends the Ethernet FCS after the last data byte of each frame, spilling into one extra beat when needed.
module eth_fcs_inserter
  import eth_pkg::*;
#(
  parameter int DATA_BYTES = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [8*DATA_BYTES-1:0] i_data,
  input  logic [DATA_BYTES-1:0]   i_keep,
  input  logic                    i_last,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [8*DATA_BYTES-1:0] o_data,
  output logic [DATA_BYTES-1:0]   o_keep,
  output logic                    o_last,
  output logic                    o_valid,
  input  logic                    i_ready
);

  localparam int DW = 8 * DATA_BYTES;

  fcs_state_t            state_q, state_d;
  logic [31:0]           res_q, res_d;
  logic [3:0]            rcnt_q, rcnt_d;
  logic [DW-1:0]         data_d;
  logic [DATA_BYTES-1:0] keep_d;
  logic                  last_d, valid_d;

  logic                  slot_free, accept, crc_rst;
  logic [DATA_BYTES-1:0] crc_vld;
  logic [31:0]           fcs;
  logic [3:0]            n;
  logic                  overflow;
  logic [DW-1:0]         lane_data;
  logic [DATA_BYTES-1:0] lane_keep;
  logic [31:0]           lane_res;

  assign slot_free = ~o_valid | i_ready;
  assign o_ready   = (state_q == PASS) & slot_free;
  assign accept    = i_valid & o_ready;
  assign crc_vld   = accept ? i_keep : '0;
  // Clearing on the last accepted beat lets the next frame start on the following cycle.
  assign crc_rst   = i_reset | (accept & i_last);

  slicing_crc #(
    .SLICE_LENGTH   (DATA_BYTES),
    .INITIAL_CRC    (CRC32_INIT),
    .INVERT_OUTPUT  (1'b1),
    .REGISTER_OUTPUT(1'b0)
  ) u_crc (
    .i_clk  (i_clk),
    .i_reset(crc_rst),
    .i_data (i_data),
    .i_valid(crc_vld),
    .o_crc  (fcs)
  );

  assign n        = keep_to_count(MAX_BYTES'(i_keep));
  assign overflow = (int'(n) + FCS_BYTES) > DATA_BYTES;

  // FCS byte k lands in lane n+k; bytes past the bus top go to the residual, packed from lane 0.
  always_comb begin
    lane_keep = i_keep;
    lane_res  = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      lane_data[8*i +: 8] = i_keep[i] ? i_data[8*i +: 8] : 8'h00;
    end
    for (int k = 0; k < FCS_BYTES; k++) begin
      if (int'(n) + k < DATA_BYTES) begin
        lane_data[8*(int'(n)+k) +: 8] = fcs[8*k +: 8];
        lane_keep[int'(n)+k]          = 1'b1;
      end else begin
        lane_res[8*(int'(n)+k-DATA_BYTES) +: 8] = fcs[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    rcnt_d  = rcnt_q;
    data_d  = o_data;
    keep_d  = o_keep;
    last_d  = o_last;
    valid_d = o_valid & ~i_ready;
    case (state_q)
      PASS: begin
        if (accept) begin
          valid_d = 1'b1;
          if (i_last) begin
            data_d = lane_data;
            keep_d = lane_keep;
            last_d = ~overflow;
            if (overflow) begin
              state_d = EXTRA;
              res_d   = lane_res;
              rcnt_d  = 4'(int'(n) + FCS_BYTES - DATA_BYTES);
            end
          end else begin
            data_d = i_data;
            keep_d = i_keep;
            last_d = 1'b0;
          end
        end
      end
      EXTRA: begin
        if (slot_free) begin
          valid_d = 1'b1;
          data_d  = DW'(res_q);
          keep_d  = DATA_BYTES'(count_to_keep(rcnt_q));
          last_d  = 1'b1;
          state_d = PASS;
        end
      end
      default: state_d = PASS;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= PASS;
      res_q   <= '0;
      rcnt_q  <= '0;
      o_data  <= '0;
      o_keep  <= '0;
      o_last  <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      rcnt_q  <= rcnt_d;
      o_data  <= data_d;
      o_keep  <= keep_d;
      o_last  <= last_d;
      o_valid <= valid_d;
    end
  end

endmodule

// File: doc/eth_fcs_inserter.md
Name: eth_fcs_inserter

Overview:
- Ethernet TX stage that appends the 4-byte FCS to each outgoing frame.
- Accepts a byte-keep streaming frame from the MAC TX path and computes the CRC-32 through an internal slicing_crc instance.
- Emits the same frame with the FCS appended in the lanes after the last data byte, adding an extra beat when those lanes overflow.
- Sits between the TX framer and the PCS/encoder.

Parameters:
DATA_BYTES, 8, bus width in bytes; legal values 4 and 8; passed to slicing_crc SLICE_LENGTH.

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous active-high reset
i_data  in  8*DATA_BYTES  input frame data, byte 0 = lane [7:0], transmitted first
i_keep  in  DATA_BYTES  input byte valid, contiguous from lane 0
i_last  in  1  last beat of frame
i_valid  in  1  input beat valid
o_ready  out  1  upstream ready
o_data  out  8*DATA_BYTES  output data
o_keep  out  DATA_BYTES  output byte valid
o_last  out  1  output last beat (includes FCS)
o_valid  out  1  output beat valid
i_ready  in  1  downstream ready

Behaviour:
- Clock and reset: single clock i_clk; i_reset is asynchronous, active-high.
- Reset values: o_valid=0, o_last=0, o_keep=0, o_data=0, state=PASS, residual register=0.
- Handshakes: input accept = i_valid & o_ready; output transfer = o_valid & i_ready.
- o_ready = (state==PASS) & (~o_valid | i_ready). It is combinational, with no dependence on i_valid.
- Output is fully registered. Latency from input accept to o_valid is 1 cycle.
- o_* hold stable while o_valid & ~i_ready.
- CRC core configuration: slicing_crc with SLICE_LENGTH=DATA_BYTES, INITIAL_CRC=FFFFFFFF, INVERT_OUTPUT=1, REGISTER_OUTPUT=0.
- CRC core drive:
  - i_data goes straight to the core.
  - Core i_valid = i_keep when input accept, else 0.
  - Core i_reset = i_reset | (input accept & i_last). The core clears synchronously after the last beat, so back-to-back frames need no gap.
  - Async reset clears the output register and FSM; the core is cleared by the same signal at the next clock edge.
- Non-last accepted beat: o_data=i_data, o_keep=i_keep, o_last=0.
- Last accepted beat, with n = number of set bits in i_keep (1..DATA_BYTES) and fcs = core o_crc (combinational, includes this beat):
  - FCS byte k (fcs[8k+7:8k], k=0..3) is placed in lane n+k.
  - If n+4 <= DATA_BYTES: all four bytes fit. o_keep = lanes 0..n+3, o_last=1, state stays PASS.
  - Else: lanes n..DATA_BYTES-1 carry FCS bytes 0..DATA_BYTES-n-1, o_keep=all ones, o_last=0. The remaining m=n+4-DATA_BYTES bytes are stored in the residual register and state goes to EXTRA.
- EXTRA state:
  - o_ready=0.
  - When the output slot is free (~o_valid | i_ready), load o_data lanes 0..m-1 = residual FCS bytes, upper lanes zero, o_keep = lanes 0..m-1, o_last=1. Then go to PASS.
  - This costs one input bubble per frame whose last beat has n > DATA_BYTES-4.
- Unused output lanes (keep=0) are driven to zero.
- Input constraints (violation is undefined):
  - i_keep must be nonzero and contiguous from lane 0.
  - Non-last beats must have all keep bits set.
  - Input is not padded to minimum frame size; that is upstream's job.
- Reset mid-frame: the partial frame is discarded, no FCS is emitted, and the next frame starts clean.

Decomposition:
- Shared package eth_pkg holds:
  - CRC32_INIT = 32'hFFFFFFFF.
  - FCS_BYTES = 4.
  - Enum fcs_state_t {PASS, EXTRA}.
  - Function keep_to_count (keep mask to byte count).
  - Function count_to_keep (byte count to keep mask).
- One sub-module: the existing slicing_crc, instantiated once. Lane placement and the FSM live in eth_fcs_inserter.

Test Plan:
1. DATA_BYTES=8, frame ASCII "123456789": beat0 "12345678" keep FF, beat1 "9" keep 01 last → out beat1 keep 1F, lanes1..4 = 26 39 F4 CB, o_last=1.
2. Frame of 4 bytes "1234" in one beat, keep 0F → single output beat, keep FF, lanes 4..7 = golden-model FCS, o_last=1, no bubble.
3. Frame "12345678" keep FF last → beat0 keep FF o_last=0. Beat1 keep 0F carries FCS (golden model), o_last=1. o_ready low exactly one cycle.
4. Back-to-back frames 1 and 3 with i_ready toggled at random 50% → outputs match golden model byte-for-byte, no data change while stalled, second frame's CRC unaffected by the first.
5. Assert i_reset asynchronously between clocks mid-frame (after beat0 of frame 1), then send frame 1 complete → o_valid drops immediately, and the next frame's FCS is again CB F4 39 26.
6. DATA_BYTES=4, frame "123456789" → last beat keep 1, FCS bytes 26 39 F4 in lanes 1..3 (o_last=0), extra beat CB keep 1 o_last=1.
